mux_pipe_n: RTL and testbench

//  Parametrised N:1, W-bit selector for the ALU result path, with two registered stages and valid/ready flow control.
//  Out-of-range selects produce zero and are flagged with the data. A saturating error counter tracks them.

---
 rtl/mux_pipe_n.sv | 124 ++++++++++++
 tb/tb_mux_pipe_n.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_pipe_n.sv
// N:1 W-bit result selector with a two-entry registered pipeline (valid/ready) and a
// saturating counter of out-of-range selects.
module mux_pipe_n #(
   parameter int N     = 10,
   parameter int W     = 32,
   parameter int SEL_W = (N > 1) ? $clog2(N) : 1,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N*W-1:0]     a,
   input  logic [SEL_W-1:0]   s,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [W-1:0]       y,
   output logic               sel_err,
   output logic               out_valid,
   input  logic               out_ready,
   input  logic               clr_err,
   output logic [CNT_W-1:0]   err_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [W-1:0]     mux_data_s;
   logic             mux_hit_s;
   logic             accept_s;
   logic             advance_s;
   logic             err_acc_s;

   logic             a_valid_q, a_valid_d;
   logic [W-1:0]     a_data_q,  a_data_d;
   logic             a_err_q,   a_err_d;
   logic             b_valid_q, b_valid_d;
   logic [W-1:0]     b_data_q,  b_data_d;
   logic             b_err_q,   b_err_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;

   // One-hot AND-OR selection; no channel matching means the select was out of range.
   always_comb begin
      mux_data_s = {W{1'b0}};
      mux_hit_s  = 1'b0;
      for (int k = 0; k < N; k++) begin
         mux_data_s = mux_data_s | (a[k*W +: W] & {W{s == SEL_W'(k)}});
         mux_hit_s  = mux_hit_s | (s == SEL_W'(k));
      end
   end

   // Handshake: B advances from A whenever B is empty or being drained.
   always_comb begin
      advance_s = a_valid_q && (!b_valid_q || out_ready);
      in_ready  = !a_valid_q || advance_s;
      accept_s  = in_valid && in_ready;
      err_acc_s = accept_s && !mux_hit_s;
   end

   // Slot A next state: loads on accept, empties when it hands its item to B.
   always_comb begin
      a_data_d = a_data_q;
      a_err_d  = a_err_q;
      if (accept_s) begin
         a_valid_d = 1'b1;
         a_data_d  = mux_data_s;
         a_err_d   = !mux_hit_s;
      end else if (advance_s) begin
         a_valid_d = 1'b0;
      end else begin
         a_valid_d = a_valid_q;
      end
   end

   // Slot B next state: data only changes on advance so held outputs stay bit-stable.
   always_comb begin
      b_data_d = b_data_q;
      b_err_d  = b_err_q;
      if (advance_s) begin
         b_valid_d = 1'b1;
         b_data_d  = a_data_q;
         b_err_d   = a_err_q;
      end else if (out_ready) begin
         b_valid_d = 1'b0;
      end else begin
         b_valid_d = b_valid_q;
      end
   end

   // Clear takes priority but still counts an out-of-range item accepted in the same cycle.
   always_comb begin
      if (clr_err) begin
         err_count_d = CNT_W'(err_acc_s);
      end else if (err_acc_s && (err_count_q != CNT_MAX)) begin
         err_count_d = err_count_q + CNT_W'(1);
      end else begin
         err_count_d = err_count_q;
      end
   end

   // Pipeline and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_valid_q   <= 1'b0;
         a_data_q    <= {W{1'b0}};
         a_err_q     <= 1'b0;
         b_valid_q   <= 1'b0;
         b_data_q    <= {W{1'b0}};
         b_err_q     <= 1'b0;
         err_count_q <= {CNT_W{1'b0}};
      end else begin
         a_valid_q   <= a_valid_d;
         a_data_q    <= a_data_d;
         a_err_q     <= a_err_d;
         b_valid_q   <= b_valid_d;
         b_data_q    <= b_data_d;
         b_err_q     <= b_err_d;
         err_count_q <= err_count_d;
      end
   end

   assign y         = b_data_q;
   assign sel_err   = b_err_q;
   assign out_valid = b_valid_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_mux_pipe_n.sv
// Directed-table and scoreboard bench for mux_pipe_n (N=10, W=32; second instance with CNT_W=4).
module tb_mux_pipe_n;

   localparam int N = 10;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [N*W-1:0] a;
   logic [3:0]    s, s4;
   logic          in_valid, in_valid4;
   logic          out_ready, out_ready4;
   logic          clr_err, clr_err4;
   logic          in_ready, in_ready4;
   logic [W-1:0]  y, y4;
   logic          sel_err, sel_err4;
   logic          out_valid, out_valid4;
   logic [15:0]   err_count;
   logic [3:0]    err_count4;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mux_pipe_n #(.N(N), .W(W), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .a(a), .s(s), .in_valid(in_valid), .in_ready(in_ready),
      .y(y), .sel_err(sel_err), .out_valid(out_valid), .out_ready(out_ready),
      .clr_err(clr_err), .err_count(err_count));

   mux_pipe_n #(.N(N), .W(W), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .a(a), .s(s4), .in_valid(in_valid4), .in_ready(in_ready4),
      .y(y4), .sel_err(sel_err4), .out_valid(out_valid4), .out_ready(out_ready4),
      .clr_err(clr_err4), .err_count(err_count4));

   typedef struct packed {
      logic        iv;
      logic [3:0]  s;
      logic        ordy;
      logic        clr;
      logic        exp_ir;
      logic        exp_ov;
      logic [31:0] exp_y;
      logic        exp_err;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t tbl [14];

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } item_t;

   item_t sb [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ch(input int k);
      if (k == 3) return 32'hDEADBEEF;
      return {16'hC0DE, 16'(k)};
   endfunction

   function automatic item_t model_mux(input logic [N*W-1:0] av, input logic [3:0] sv);
      item_t r;
      if (int'(sv) < N) begin
         r.data = av[int'(sv)*W +: W];
         r.err  = 1'b0;
      end else begin
         r.data = 32'h0;
         r.err  = 1'b1;
      end
      return r;
   endfunction

   initial begin
      int    occ;
      int    mcnt;
      int    drain;
      logic  acc;
      logic  exp_ir;
      item_t it;

      rst = 1'b1;
      s = 4'd0; in_valid = 1'b0; out_ready = 1'b1; clr_err = 1'b0;
      s4 = 4'd0; in_valid4 = 1'b0; out_ready4 = 1'b1; clr_err4 = 1'b0;
      for (int k = 0; k < N; k++) a[k*W +: W] = ch(k);
      #12;
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset y", y, 32'h0);
      chk("reset sel_err", 32'(sel_err), 32'd0);
      chk("reset err_count", 32'(err_count), 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;
      @(posedge clk); #1;

      //             iv    s      ordy  clr   ir    ov    y             err   cnt
      tbl[0]  = '{1'b1, 4'd3,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 16'd0};
      tbl[1]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 16'd0};
      tbl[2]  = '{1'b1, 4'd12, 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 16'd1};
      tbl[3]  = '{1'b1, 4'd9,  1'b1, 1'b0, 1'b1, 1'b1, 32'h0,        1'b1, 16'd1};
      tbl[4]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1, 32'hC0DE0009, 1'b0, 16'd1};
      tbl[5]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 32'hC0DE0009, 1'b0, 16'd1};
      tbl[6]  = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'hC0DE0009, 1'b0, 16'd1};
      tbl[7]  = '{1'b1, 4'd1,  1'b0, 1'b0, 1'b1, 1'b1, 32'hC0DE0000, 1'b0, 16'd1};
      tbl[8]  = '{1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 1'b1, 32'hC0DE0000, 1'b0, 16'd1};
      tbl[9]  = '{1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 1'b1, 32'hC0DE0000, 1'b0, 16'd1};
      tbl[10] = '{1'b1, 4'd2,  1'b1, 1'b0, 1'b1, 1'b1, 32'hC0DE0001, 1'b0, 16'd1};
      tbl[11] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1, 32'hC0DE0002, 1'b0, 16'd1};
      tbl[12] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 32'hC0DE0002, 1'b0, 16'd1};
      tbl[13] = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 32'hC0DE0002, 1'b0, 16'd0};

      for (int i = 0; i < 14; i++) begin
         in_valid = tbl[i].iv; s = tbl[i].s; out_ready = tbl[i].ordy; clr_err = tbl[i].clr;
         #1;
         chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].exp_ir));
         @(posedge clk); #1;
         chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
         chk($sformatf("vec%0d y", i), y, tbl[i].exp_y);
         chk($sformatf("vec%0d sel_err", i), 32'(sel_err), 32'(tbl[i].exp_err));
         chk($sformatf("vec%0d err_count", i), 32'(err_count), 32'(tbl[i].exp_cnt));
      end
      clr_err = 1'b0;

      // Full-rate stream: 20 items, out_valid contiguous after the fill.
      out_ready = 1'b1;
      for (int e = 0; e < 22; e++) begin
         in_valid = (e < 20);
         s = 4'(e % 10);
         @(posedge clk); #1;
         if (e >= 1 && e <= 20) begin
            chk($sformatf("stream%0d out_valid", e), 32'(out_valid), 32'd1);
            chk($sformatf("stream%0d y", e), y, ch((e - 1) % 10));
         end else begin
            chk($sformatf("stream%0d out_valid", e), 32'(out_valid), 32'd0);
         end
      end

      // Saturation on the 4-bit counter instance.
      in_valid4 = 1'b1; s4 = 4'd12; out_ready4 = 1'b1;
      repeat (17) @(posedge clk);
      #1;
      chk("sat err_count4", 32'(err_count4), 32'hF);
      chk("sat sel_err4", 32'(sel_err4), 32'd1);
      chk("sat y4", y4, 32'h0);
      clr_err4 = 1'b1;
      @(posedge clk); #1;
      chk("clr+err err_count4", 32'(err_count4), 32'd1);
      in_valid4 = 1'b0;
      @(posedge clk); #1;
      chk("clr only err_count4", 32'(err_count4), 32'd0);
      clr_err4 = 1'b0;

      // Fill both slots with bad selects under backpressure, then reset mid-transfer.
      out_ready = 1'b0; in_valid = 1'b1; s = 4'd12;
      repeat (2) @(posedge clk);
      #1;
      chk("full in_ready", 32'(in_ready), 32'd0);
      chk("full out_valid", 32'(out_valid), 32'd1);
      chk("full err_count", 32'(err_count), 32'd2);
      #1 rst = 1'b1;
      #1;
      chk("midrst out_valid", 32'(out_valid), 32'd0);
      chk("midrst y", y, 32'h0);
      chk("midrst sel_err", 32'(sel_err), 32'd0);
      chk("midrst err_count", 32'(err_count), 32'd0);
      chk("midrst in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Random traffic against a queue scoreboard and occupancy model.
      occ = 0; mcnt = 0;
      for (int c = 0; c < 1024 + 12; c++) begin
         for (int k = 0; k < N; k++) a[k*W +: W] = $urandom;
         s = 4'($urandom_range(15, 0));
         if (c < 1024) begin
            in_valid  = ($urandom_range(3, 0) != 0);
            out_ready = ($urandom_range(3, 0) != 0);
            clr_err   = ($urandom_range(31, 0) == 0);
         end else begin
            in_valid = 1'b0; out_ready = 1'b1; clr_err = 1'b0;
         end
         #1;
         exp_ir = (occ < 2) || out_ready;
         chk("rnd in_ready", 32'(in_ready), 32'(exp_ir));
         acc = in_valid && exp_ir;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("rnd spurious out_valid", 32'd1, 32'd0);
            end else begin
               it = sb.pop_front();
               chk("rnd y", y, it.data);
               chk("rnd sel_err", 32'(sel_err), 32'(it.err));
               occ--;
            end
         end
         if (acc) begin
            it = model_mux(a, s);
            sb.push_back(it);
            occ++;
         end
         if (clr_err) mcnt = (acc && it.err) ? 1 : 0;
         else if (acc && it.err && mcnt < 65535) mcnt++;
         @(posedge clk); #1;
         chk("rnd err_count", 32'(err_count), 32'(mcnt));
      end
      drain = sb.size();
      chk("rnd scoreboard empty", 32'(drain), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
